enc8to3_seq: RTL and testbench

- Sequential counterpart of the team's 3-to-8 active-low decoder.
- Captures an 8-bit active-low request vector in the decoder's output format.
- Emits the 3-bit code {A,B,C} of every asserted line, one per valid/ready handshake, in priority order.
- Sits between the decoder-side select lines and any consumer that needs indices back, e.g. a loopback checker or an interrupt source encoder.

---
 rtl/enc8to3_seq_pkg.sv | 19 +
 rtl/enc8to3_seq_prienc8.sv | 35 +++
 rtl/enc8to3_seq.sv | 144 ++++++++++++++
 tb/tb_enc8to3_seq.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/enc8to3_seq_pkg.sv
// Shared definitions for the sequential 8-to-3 encoder: FSM encoding,
// default code width and count-width helper.
package enc8to3_seq_pkg;

    localparam int unsigned WDefault = 3;

    typedef enum logic {
        StIdle = 1'b0,
        StEmit = 1'b1
    } state_e;

    // Counter must represent 0..2**w inclusive.
    function automatic int unsigned count_width(input int unsigned w);
        return w + 1;
    endfunction

    localparam int unsigned CountWDefault = count_width(WDefault);

endpackage

// File: rtl/enc8to3_seq_prienc8.sv
// Combinational N-to-W priority encoder; LSB_FIRST picks the lowest set
// index, otherwise the highest set index wins.
module enc8to3_seq_prienc8
    import enc8to3_seq_pkg::*;
#(
    parameter int unsigned W         = WDefault,
    parameter bit          LSB_FIRST = 1'b1
) (
    input  logic [(2**W)-1:0] req_i,
    output logic [W-1:0]      idx_o,
    output logic              any_o
);

    localparam int N = 2 ** W;

    always_comb begin
        idx_o = '0;
        any_o = |req_i;
        if (LSB_FIRST) begin
            // Scan downwards so the lowest set index is written last.
            for (int i = N - 1; i >= 0; i--) begin
                if (req_i[i]) begin
                    idx_o = W'(i);
                end
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (req_i[i]) begin
                    idx_o = W'(i);
                end
            end
        end
    end

endmodule

// File: rtl/enc8to3_seq.sv
// Captures an active-low request vector and emits the code of every asserted
// line over a valid/ready handshake, in priority order.
module enc8to3_seq
    import enc8to3_seq_pkg::*;
#(
    parameter int unsigned W         = WDefault,
    parameter bit          LSB_FIRST = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  EN,
    input  logic [(2**W)-1:0]     Y,
    input  logic                  load,
    output logic                  A,
    output logic                  B,
    output logic                  C,
    output logic                  valid,
    input  logic                  ready,
    output logic                  busy,
    output logic [count_width(W)-1:0] count,
    output logic                  none
);

    localparam int          N  = 2 ** W;
    localparam int unsigned CW = count_width(W);

    state_e         state_q, state_d;
    logic [N-1:0]   pending_q, pending_d;
    logic [W-1:0]   code_q, code_d;
    logic           valid_q, valid_d;
    logic           busy_q, busy_d;
    logic [CW-1:0]  count_q, count_d;
    logic           none_q, none_d;

    logic [W-1:0]   enc_idx;
    logic           enc_any;
    logic [CW-1:0]  req_cnt;

    // Pending set after this edge; the encoder looks ahead at it so the next
    // code is ready in the cycle right after a transfer.
    always_comb begin
        pending_d = pending_q;
        if (EN) begin
            pending_d = '0;
        end else if (state_q == StIdle) begin
            if (load) begin
                pending_d = ~Y;
            end
        end else if (ready) begin
            pending_d[code_q] = 1'b0;
        end
    end

    always_comb begin
        req_cnt = '0;
        for (int i = 0; i < N; i++) begin
            if (!Y[i]) begin
                req_cnt = req_cnt + CW'(1);
            end
        end
    end

    enc8to3_seq_prienc8 #(
        .W         (W),
        .LSB_FIRST (LSB_FIRST)
    ) u_prienc (
        .req_i (pending_d),
        .idx_o (enc_idx),
        .any_o (enc_any)
    );

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        count_d = count_q;
        none_d  = 1'b0;
        if (EN) begin
            state_d = StIdle;
            valid_d = 1'b0;
            busy_d  = 1'b0;
            count_d = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (load) begin
                        if (enc_any) begin
                            state_d = StEmit;
                            code_d  = enc_idx;
                            valid_d = 1'b1;
                            busy_d  = 1'b1;
                            count_d = req_cnt;
                        end else begin
                            none_d = 1'b1;
                        end
                    end
                end
                StEmit: begin
                    if (ready) begin
                        count_d = count_q - CW'(1);
                        if (enc_any) begin
                            code_d = enc_idx;
                        end else begin
                            state_d = StIdle;
                            valid_d = 1'b0;
                            busy_d  = 1'b0;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            pending_q <= '0;
            code_q    <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            count_q   <= '0;
            none_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            code_q    <= code_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
            count_q   <= count_d;
            none_q    <= none_d;
        end
    end

    assign A     = code_q[W-1];
    assign B     = code_q[W-2];
    assign C     = code_q[0];
    assign valid = valid_q;
    assign busy  = busy_q;
    assign count = count_q;
    assign none  = none_q;

endmodule

// File: tb/tb_enc8to3_seq.sv
// Scoreboard bench: two encoders (lowest-first and highest-first) share one
// stimulus stream; a queue model predicts codes, a negedge monitor checks them.
module tb_enc8to3_seq;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [7:0] y;
    logic       load;
    logic       ready;

    logic       a_l, b_l, c_l, valid_l, busy_l, none_l;
    logic [3:0] count_l;
    logic       a_m, b_m, c_m, valid_m, busy_m, none_m;
    logic [3:0] count_m;

    int checks   = 0;
    int failures = 0;

    int model_left = 0;
    bit exp_none   = 1'b0;
    int exp_lsb[$];
    int exp_msb[$];
    int xfer_l = 0;
    int xfer_m = 0;

    enc8to3_seq #(.W(3), .LSB_FIRST(1'b1)) u_lsb (
        .clk   (clk),
        .rst_n (rst_n),
        .EN    (en),
        .Y     (y),
        .load  (load),
        .A     (a_l),
        .B     (b_l),
        .C     (c_l),
        .valid (valid_l),
        .ready (ready),
        .busy  (busy_l),
        .count (count_l),
        .none  (none_l)
    );

    enc8to3_seq #(.W(3), .LSB_FIRST(1'b0)) u_msb (
        .clk   (clk),
        .rst_n (rst_n),
        .EN    (en),
        .Y     (y),
        .load  (load),
        .A     (a_m),
        .B     (b_m),
        .C     (c_m),
        .valid (valid_m),
        .ready (ready),
        .busy  (busy_m),
        .count (count_m),
        .none  (none_m)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a load accepted while idle queues every requested index
    // in ascending and in descending order; each transfer consumes one.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_left = 0;
            exp_none   = 1'b0;
            exp_lsb.delete();
            exp_msb.delete();
        end else begin
            exp_none = 1'b0;
            if (en) begin
                model_left = 0;
                exp_lsb.delete();
                exp_msb.delete();
            end else if (model_left == 0) begin
                if (load) begin
                    for (int i = 0; i < 8; i++) if (!y[i]) exp_lsb.push_back(i);
                    for (int i = 7; i >= 0; i--) if (!y[i]) exp_msb.push_back(i);
                    model_left = exp_lsb.size();
                    if (model_left == 0) exp_none = 1'b1;
                end
            end else if (ready) begin
                model_left--;
            end
        end
    end

    // Monitor: compares status every cycle and the presented code against the
    // scoreboard head; a handshake pops it.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("valid_lsb", int'(valid_l), int'(model_left > 0));
            chk("busy_lsb", int'(busy_l), int'(model_left > 0));
            chk("count_lsb", int'(count_l), model_left);
            chk("none_lsb", int'(none_l), int'(exp_none));
            chk("valid_msb", int'(valid_m), int'(model_left > 0));
            chk("busy_msb", int'(busy_m), int'(model_left > 0));
            chk("count_msb", int'(count_m), model_left);
            chk("none_msb", int'(none_m), int'(exp_none));
            if (valid_l) begin
                if (exp_lsb.size() == 0) begin
                    chk("lsb_unexpected_code", int'({a_l, b_l, c_l}), -1);
                end else begin
                    chk("code_lsb", int'({a_l, b_l, c_l}), exp_lsb[0]);
                    if (ready) begin
                        void'(exp_lsb.pop_front());
                        xfer_l++;
                    end
                end
            end
            if (valid_m) begin
                if (exp_msb.size() == 0) begin
                    chk("msb_unexpected_code", int'({a_m, b_m, c_m}), -1);
                end else begin
                    chk("code_msb", int'({a_m, b_m, c_m}), exp_msb[0]);
                    if (ready) begin
                        void'(exp_msb.pop_front());
                        xfer_m++;
                    end
                end
            end
        end
    end

    task automatic cyc(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk_cleared(input string tag);
        chk({tag, "_abc_lsb"}, int'({a_l, b_l, c_l}), 0);
        chk({tag, "_valid_lsb"}, int'(valid_l), 0);
        chk({tag, "_busy_lsb"}, int'(busy_l), 0);
        chk({tag, "_count_lsb"}, int'(count_l), 0);
        chk({tag, "_none_lsb"}, int'(none_l), 0);
        chk({tag, "_abc_msb"}, int'({a_m, b_m, c_m}), 0);
        chk({tag, "_valid_msb"}, int'(valid_m), 0);
        chk({tag, "_busy_msb"}, int'(busy_m), 0);
        chk({tag, "_count_msb"}, int'(count_m), 0);
    endtask

    task automatic do_load(input logic [7:0] yv, input logic rdy);
        y     = yv;
        load  = 1'b1;
        ready = rdy;
        cyc();
        load  = 1'b0;
    endtask

    initial begin
        int base_l;
        int base_m;
        rst_n = 1'b0;
        en    = 1'b0;
        y     = 8'hFF;
        load  = 1'b0;
        ready = 1'b0;
        #12;
        chk_cleared("reset");
        cyc();
        rst_n = 1'b1;
        cyc(2);

        // Indices 0 and 5 with ready held high.
        base_l = xfer_l;
        do_load(8'b1101_1110, 1'b1);
        cyc(4);
        chk("t1_xfers_lsb", xfer_l - base_l, 2);

        // All lines requested; ready low 3 cycles before each accept.
        base_l = xfer_l;
        base_m = xfer_m;
        do_load(8'h00, 1'b0);
        for (int k = 0; k < 8; k++) begin
            ready = 1'b0;
            cyc(3);
            ready = 1'b1;
            cyc();
        end
        ready = 1'b0;
        cyc(2);
        chk("t2_xfers_lsb", xfer_l - base_l, 8);
        chk("t2_xfers_msb", xfer_m - base_m, 8);
        chk("t2_drain", exp_lsb.size() + exp_msb.size(), 0);

        // No line asserted.
        do_load(8'hFF, 1'b1);
        cyc(3);

        // Abort on the third presented code with ready high.
        base_l = xfer_l;
        do_load(8'h00, 1'b1);
        cyc(2);
        en = 1'b1;
        load = 1'b1;
        cyc();
        en = 1'b0;
        load = 1'b0;
        cyc(2);
        chk("t4_xfers_lsb", xfer_l - base_l, 3);
        base_l = xfer_l;
        do_load(8'b1110_0111, 1'b1);
        cyc(4);
        chk("t4_reload_xfers", xfer_l - base_l, 2);

        // Indices 7 and 1; a second load during EMIT is ignored.
        base_m = xfer_m;
        do_load(8'b0111_1101, 1'b0);
        cyc();
        do_load(8'hFE, 1'b0);
        ready = 1'b1;
        cyc(4);
        chk("t5_xfers_msb", xfer_m - base_m, 2);

        // Reset between edges while emitting.
        do_load(8'h00, 1'b0);
        cyc();
        #2;
        rst_n = 1'b0;
        #1;
        chk_cleared("async_rst");
        cyc();
        rst_n = 1'b1;
        cyc(2);

        // Randomized traffic.
        for (int k = 0; k < 3000; k++) begin
            int r;
            r     = int'($urandom_range(0, 7));
            y     = (r == 0) ? 8'h00 : (r == 1) ? 8'hFF : 8'($urandom);
            load  = ($urandom_range(0, 3) == 0);
            en    = ($urandom_range(0, 23) == 0);
            ready = ($urandom_range(0, 1) == 1);
            cyc();
        end
        load  = 1'b0;
        en    = 1'b0;
        ready = 1'b1;
        cyc(12);
        chk("final_drain", exp_lsb.size() + exp_msb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
